seg_serial_shifter: RTL and testbench

- Downstream stage of the 8-digit hex-to-segment encoder.
- Captures its 64-bit segment word (SEG_TXT) and shifts it MSB-first into the board's cascaded serial-in/parallel-out shift registers through a 4-wire interface: serial clock, serial data, clear, and output latch/enable.
- Sits between the display encoder and the board pins.
- Each transfer is a start/busy/done handshake driven by the display refresh controller.

---
 rtl/seg_serial_shifter.sv | 124 ++++++++++++
 tb/tb_seg_serial_shifter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_shifter.sv
// Serial output stage for the 8-digit segment display.
// Captures the parallel segment word and shifts it MSB-first into the
// board's cascaded SIPO registers over s_clk / s_data, then pulses s_en
// to latch the outputs. s_clr_n is held low only while reset is asserted.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; done pulses here for one cycle
//   SHIFT_LO | s_clk low for DIV cycles, s_data set up for the next rise
//   SHIFT_HI | s_clk high for DIV cycles, s_data held past the rise
//   LATCH    | all bits shifted, s_en high for DIV cycles
module seg_serial_shifter #(
   parameter int DATA_BITS = 64,
   parameter int DIV       = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] P_Data,
   output logic                 busy,
   output logic                 done,
   output logic                 s_clk,
   output logic                 s_data,
   output logic                 s_clr_n,
   output logic                 s_en
);

   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int PW = $clog2(DIV + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   state_t               state;
   // The MSB goes straight to s_data on accept, so only the remaining
   // bits need storing.
   logic [DATA_BITS-2:0] rest;
   logic [BW-1:0]        bit_cnt;
   logic [PW-1:0]        phase_cnt;
   logic                 phase_end;

   assign phase_end = (phase_cnt == PH_LAST);

   // Transfer sequencer: every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rest      <= '0;
         bit_cnt   <= '0;
         phase_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         s_clk     <= 1'b0;
         s_data    <= 1'b0;
         s_en      <= 1'b0;
         s_clr_n   <= 1'b0;
      end else begin
         s_clr_n <= 1'b1;
         done    <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rest      <= P_Data[DATA_BITS-2:0];
                  s_data    <= P_Data[DATA_BITS-1];
                  s_clk     <= 1'b0;
                  busy      <= 1'b1;
                  bit_cnt   <= BIT_LAST;
                  phase_cnt <= '0;
                  state     <= SHIFT_LO;
               end
            end
            SHIFT_LO: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  s_clk     <= 1'b1;
                  state     <= SHIFT_HI;
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            SHIFT_HI: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  s_clk     <= 1'b0;
                  if (bit_cnt != '0) begin
                     // Data changes only on the falling edge, giving DIV
                     // cycles of hold after the rise and setup before the next.
                     s_data  <= rest[DATA_BITS-2];
                     rest    <= rest << 1;
                     bit_cnt <= bit_cnt - BW'(1);
                     state   <= SHIFT_LO;
                  end else begin
                     s_data <= 1'b0;
                     s_en   <= 1'b1;
                     state  <= LATCH;
                  end
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            LATCH: begin
               if (phase_end) begin
                  phase_cnt <= '0;
                  s_en      <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Bench for seg_serial_shifter: one DIV=2 and one DIV=1 instance.
// Stimulus pushes each accepted word into a per-instance queue; a monitor
// per instance models the external 64-bit SIPO chain, measures timing and
// compares against the queue head when done pulses.
module tb_seg_serial_shifter;

   localparam int NB = 64;

   logic          clk = 1'b0;
   logic          rst_n   [2];
   logic          start   [2];
   logic [NB-1:0] p_data  [2];
   logic          busy    [2];
   logic          done    [2];
   logic          s_clk   [2];
   logic          s_data  [2];
   logic          s_clr_n [2];
   logic          s_en    [2];

   int errors = 0;
   int checks = 0;

   logic [NB-1:0] q0[$];
   logic [NB-1:0] q1[$];

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(int u, logic [NB-1:0] w);
      if (u == 0) q0.push_back(w);
      else        q1.push_back(w);
   endfunction

   function automatic int exp_size(int u);
      return (u == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [NB-1:0] pop_exp(int u);
      if (u == 0) return q0.pop_front();
      else        return q1.pop_front();
   endfunction

   function automatic void flush_exp(int u);
      if (u == 0) q0.delete();
      else        q1.delete();
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_u
      localparam int D = (g == 0) ? 2 : 1;

      seg_serial_shifter #(.DATA_BITS(NB), .DIV(D)) dut (
         .clk     (clk),
         .rst_n   (rst_n[g]),
         .start   (start[g]),
         .P_Data  (p_data[g]),
         .busy    (busy[g]),
         .done    (done[g]),
         .s_clk   (s_clk[g]),
         .s_data  (s_data[g]),
         .s_clr_n (s_clr_n[g]),
         .s_en    (s_en[g])
      );

      int            cyc, rises, busy_cyc, sen_cyc, bad_timing;
      bit            in_xfer = 1'b0;
      bit            got_cap;
      logic [NB-1:0] sipo, cap, w;
      logic          pclk = 1'b0, pen = 1'b0, pbusy = 1'b0, pdone = 1'b0;

      always @(negedge clk) begin
         if (s_clr_n[g] === 1'b0) begin
            chk($sformatf("u%0d reset outputs", g),
                NB'({busy[g], done[g], s_clk[g], s_en[g], s_data[g]}), '0);
            in_xfer = 1'b0;
            flush_exp(g);
         end else begin
            if (done[g]) chk($sformatf("u%0d done width", g), NB'(pdone), '0);
            if (busy[g] && !pbusy) begin
               in_xfer = 1'b1;
               cyc = 0; rises = 0; busy_cyc = 0; sen_cyc = 0; bad_timing = 0;
               sipo = '0; cap = '0; got_cap = 1'b0;
            end else if (in_xfer) begin
               cyc++;
            end
            if (in_xfer) begin
               if (busy[g]) busy_cyc++;
               if (s_clk[g] && !pclk) begin
                  sipo = {sipo[NB-2:0], s_data[g]};
                  rises++;
                  if (cyc != D + 2 * D * (rises - 1)) bad_timing++;
               end
               if (s_en[g]) begin
                  sen_cyc++;
                  if (!pen) begin
                     cap = sipo;
                     got_cap = 1'b1;
                     if (cyc != 2 * D * NB) bad_timing++;
                  end
               end
               if (done[g]) begin
                  in_xfer = 1'b0;
                  chk($sformatf("u%0d done has expectation", g), NB'(exp_size(g) > 0), NB'(1));
                  if (exp_size(g) > 0) begin
                     w = pop_exp(g);
                     chk($sformatf("u%0d latched word", g), cap, w);
                     chk($sformatf("u%0d s_clk rises", g), NB'(rises), NB'(NB));
                     chk($sformatf("u%0d busy cycles", g), NB'(busy_cyc), NB'(2 * D * NB + D));
                     chk($sformatf("u%0d s_en cycles", g), NB'(sen_cyc), NB'(D));
                     chk($sformatf("u%0d edge timing errs", g), NB'(bad_timing), '0);
                     chk($sformatf("u%0d s_en seen", g), NB'(got_cap), NB'(1));
                     chk($sformatf("u%0d busy low at done", g), NB'(busy[g]), '0);
                  end
               end
            end else if (done[g]) begin
               chk($sformatf("u%0d done outside transfer", g), NB'(done[g]), '0);
            end
         end
         pclk  = s_clk[g];
         pen   = s_en[g];
         pbusy = busy[g];
         pdone = done[g];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(int u, logic [NB-1:0] w);
      int n = 0;
      while (busy[u] && n < 600) begin
         step();
         n++;
      end
      p_data[u] = w;
      start[u]  = 1'b1;
      push_exp(u, w);
      step();
      start[u]  = 1'b0;
      chk($sformatf("u%0d accept", u), NB'(busy[u]), NB'(1));
   endtask

   task automatic wait_done(int u);
      int n = 0;
      while (!done[u] && n < 600) begin
         step();
         n++;
      end
      chk($sformatf("u%0d done seen", u), NB'(done[u]), NB'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [NB-1:0] w1, w2;
      for (int u = 0; u < 2; u++) begin
         rst_n[u]  = 1'b0;
         start[u]  = 1'b0;
         p_data[u] = '0;
      end

      // reset held for 3 cycles, then released
      repeat (3) begin
         step();
         chk("s_clr_n in reset", NB'(s_clr_n[0]), '0);
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      step();
      chk("s_clr_n after release u0", NB'(s_clr_n[0]), NB'(1));
      chk("s_clr_n after release u1", NB'(s_clr_n[1]), NB'(1));
      chk("idle outputs u0", NB'({busy[0], done[0], s_clk[0], s_en[0]}), '0);
      step();

      // single transfer with single-bit markers at both ends
      start_xfer(0, 64'h8000_0000_0000_0001);
      wait_done(0);
      step();

      // pattern integrity; P_Data disturbed during the transfer
      start_xfer(0, 64'hFEDC_BA98_7654_3210);
      repeat (5) step();
      p_data[0] = '0;
      repeat (40) step();
      p_data[0] = {$urandom, $urandom};
      wait_done(0);

      // start pulsed while busy is ignored
      start_xfer(0, {$urandom, $urandom});
      repeat (9) step();
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      wait_done(0);
      repeat (5) step();
      chk("no queued start", NB'(busy[0]), '0);

      // back-to-back with start held high
      w1 = {$urandom, $urandom};
      w2 = {$urandom, $urandom};
      p_data[0] = w1;
      start[0]  = 1'b1;
      push_exp(0, w1);
      step();
      chk("b2b first accept", NB'(busy[0]), NB'(1));
      wait_done(0);
      p_data[0] = w2;
      push_exp(0, w2);
      step();
      chk("b2b accept on done cycle", NB'(busy[0]), NB'(1));
      step();
      chk("b2b s_clk low", NB'(s_clk[0]), '0);
      step();
      chk("b2b first rise", NB'(s_clk[0]), NB'(1));
      start[0] = 1'b0;
      wait_done(0);

      // random words with random idle gaps
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 4)) step();
         start_xfer(0, {$urandom, $urandom});
         wait_done(0);
      end

      // reset after 20 bits
      start_xfer(0, {$urandom, $urandom});
      repeat (80) step();
      rst_n[0] = 1'b0;
      step();
      chk("mid-reset s_clk", NB'(s_clk[0]), '0);
      chk("mid-reset s_clr_n", NB'(s_clr_n[0]), '0);
      chk("mid-reset busy", NB'(busy[0]), '0);
      chk("mid-reset done", NB'(done[0]), '0);
      rst_n[0] = 1'b1;
      repeat (10) step();
      start_xfer(0, {$urandom, $urandom});
      wait_done(0);

      // DIV=1 instance
      start_xfer(1, 64'hAAAA_AAAA_AAAA_AAAA);
      wait_done(1);
      start_xfer(1, {$urandom, $urandom});
      wait_done(1);

      repeat (5) step();
      chk("scoreboard drained", NB'(q0.size() + q1.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
